// File: rtl/abs_sample_demux.sv
// abs_sample_demux: converts a channel-ordered sample stream to saturated absolute values and demuxes them into 8 slots
module abs_sample_demux #(
    parameter bit OFFSET_BINARY = 1'b0
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         enable,
    input  logic [15:0]  sample_data,
    input  logic         sample_valid,
    output logic         sample_ready,
    input  logic         sample_last,
    output logic [119:0] abs_value_out_concat,
    output logic [7:0]   value_ready_concat,
    output logic         frame_done,
    output logic         clip_seen,
    output logic         err_sequence
);
    typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;
    state_t state, state_nx;
    logic [2:0] ch, s1_tag;
    logic [15:0] x, s1_x, neg;
    logic s1_valid, accept, aligned, sat;
    logic [14:0] abs_val;
    assign x = {sample_data[15] ^ OFFSET_BINARY, sample_data[14:0]};
    assign accept = sample_valid & sample_ready;
    assign aligned = sample_last == (ch == 3'd7);
    assign neg = ~s1_x + 16'd1;
    assign sat = s1_x == 16'h8000;
    assign abs_val = sat ? 15'h7fff : s1_x[15] ? neg[14:0] : s1_x[14:0];
    always_ff @(posedge clk) begin
        if (!aresetn) state <= IDLE;
        else state <= state_nx;
    end
    // a misaligned beat takes priority over a simultaneous enable drop
    always_comb begin
        state_nx = (state == IDLE) ? (enable ? RUN : IDLE) :
                   (state == RUN)  ? ((accept && !aligned) ? ERROR : enable ? RUN : IDLE) :
                   ERROR;
    end
    always_comb begin
        sample_ready = (state == RUN) && enable;
    end
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ch       <= 3'd0;
            s1_valid <= 1'b0;
            s1_x     <= 16'd0;
            s1_tag   <= 3'd0;
        end else begin
            ch       <= (state != RUN || !enable) ? 3'd0 : (accept && aligned) ? ch + 3'd1 : ch;
            s1_valid <= accept && aligned;
            if (accept) begin
                s1_x   <= x;
                s1_tag <= ch;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            abs_value_out_concat <= '0;
            value_ready_concat   <= 8'd0;
            frame_done           <= 1'b0;
            clip_seen            <= 1'b0;
            err_sequence         <= 1'b0;
        end else begin
            value_ready_concat <= s1_valid ? 8'd1 << s1_tag : 8'd0;
            frame_done         <= s1_valid && s1_tag == 3'd7;
            clip_seen          <= clip_seen | (s1_valid & sat);
            err_sequence       <= err_sequence | (accept & ~aligned);
            if (s1_valid) abs_value_out_concat[s1_tag*15 +: 15] <= abs_val;
        end
    end
endmodule
